cdb_arbiter: RTL and testbench
==============================

CDB_ARBITER -- requirements
Module: cdb_arbiter

Interface
REQ-001 SHALL have parameter NUM_FU, default 4, meaning the number of functional-unit requesters.
REQ-002 SHALL have parameter CDB_SZ, default 2, meaning the number of broadcast lanes per cycle; legal range 1..NUM_FU.
REQ-003 SHALL have parameter DATA_W, default 32, meaning the result value width.
REQ-004 clock  input  1  single clock; all state updates on its rising edge.
REQ-005 reset  input  1  synchronous, active-high reset.
REQ-006 flush  input  1  squash; suppresses all grants this cycle.
REQ-007 req_valid  input  NUM_FU  per-FU completed-result request.
REQ-008 req_tag  input  NUM_FU x PHYS_REG_BITS  per-FU destination physical tag.
REQ-009 req_value  input  NUM_FU x DATA_W  per-FU result value.
REQ-010 grant  output  NUM_FU  combinational, same cycle; FU i may retire its result when grant[i]=1.
REQ-011 cdb_valid  output  CDB_SZ  registered per-lane broadcast valid.
REQ-012 cdb_tag  output  CDB_SZ x PHYS_REG_BITS  registered per-lane tag.
REQ-013 cdb_value  output  CDB_SZ x DATA_W  registered per-lane value.

Function
REQ-014 Each cycle SHALL grant up to CDB_SZ requesters, scanning FU indices circularly from rr_ptr upward.
REQ-015 The k-th granted FU in scan order SHALL occupy lane k; lanes beyond the grant count SHALL be invalid.
REQ-016 grant[i] SHALL be 1 only if req_valid[i]=1, flush=0 and reset=0.
REQ-017 Ungranted requesters SHALL receive grant=0; each FU holds req_valid/tag/value until granted, and the block stores no request.
REQ-018 Latency SHALL be one cycle: a lane filled in cycle N SHALL appear on cdb_valid/tag/value in cycle N+1 only.
REQ-019 Invalid lanes SHALL drive tag 0 and value 0.
REQ-020 rr_ptr (ceil(log2 NUM_FU) bits) SHALL become (index of last FU granted in scan order + 1) mod NUM_FU when any grant occurs; otherwise it is unchanged.
REQ-021 rr_ptr wrap SHALL be modulo NUM_FU, including non-power-of-two NUM_FU.
REQ-022 When req_valid count <= CDB_SZ, all requesters SHALL be granted in that cycle.
REQ-023 flush=1 SHALL force all grants 0, all lanes invalid next cycle, rr_ptr unchanged; flush does not clear outputs already registered for the current cycle.
REQ-024 No FU SHALL be granted more than once per cycle; no lane SHALL carry two FUs.
REQ-025 Any requester continuously asserted SHALL be granted within ceil(NUM_FU/CDB_SZ) cycles (starvation bound).

Reset
REQ-026 While reset=1: grant=0, cdb_valid=0, cdb_tag=0, cdb_value=0 next edge, rr_ptr=0.
REQ-027 Reset asserted mid-operation SHALL discard pending lanes; requests presented during reset are not granted and are not lost (FU still holds them).
REQ-028 First cycle after reset deassertion SHALL arbitrate normally from rr_ptr=0.

Structure
REQ-029 PHYS_REG_BITS and a cdb_packet_t typedef (valid, tag, value) SHALL live in the shared sys_defs package; output lanes are arrays of cdb_packet_t.
REQ-030 A sub-module rr_select (one-hot circular priority pick from a start pointer, parametrised in NUM_FU) SHALL be instantiated per lane with already-chosen requesters masked.

Verification (NUM_FU=4, CDB_SZ=2, DATA_W=32)
REQ-031 Reset, then req_valid=0000 -> grant=0000; next cycle cdb_valid=00, tags/values 0, rr_ptr=0.
REQ-032 rr_ptr=0, req_valid=1011, tags FU0=5, FU1=9, FU3=12 -> grant=0011; next cycle lane0 tag 5, lane1 tag 9, cdb_valid=11; rr_ptr=2.
REQ-033 Hold FU3 asserted, rr_ptr=2, req_valid=1000 -> grant=1000; next cycle lane0 tag 12, lane1 invalid with tag 0; rr_ptr wraps to 0.
REQ-034 All four FUs asserted continuously for 4 cycles from rr_ptr=0 -> grants 0011, 1100, 0011, 1100; each FU broadcast exactly twice.
REQ-035 req_valid=1111 with flush=1 -> grant=0000, next cycle cdb_valid=00, rr_ptr unchanged; reset asserted while lanes valid -> cdb_valid=00 and rr_ptr=0 next edge.

Source files
------------

// File: rtl/sys_defs.sv
// Shared definitions for the result-broadcast path: physical tag width and the
// common data bus packet carried on each broadcast lane.
package sys_defs;

  localparam int unsigned PHYS_REG_BITS = 6;
  localparam int unsigned XLEN          = 64;

  // value is sized for the widest datapath; narrower users zero-extend
  typedef struct packed {
    logic                     valid;
    logic [PHYS_REG_BITS-1:0] tag;
    logic [XLEN-1:0]          value;
  } cdb_packet_t;

endpackage

// File: rtl/rr_select.sv
// One-hot circular priority pick: first asserted request at or after start,
// wrapping modulo NUM_FU.
module rr_select #(
  parameter int unsigned NUM_FU = 4,
  parameter int unsigned PTR_W  = 2
) (
  input  logic [NUM_FU-1:0] req,
  input  logic [PTR_W-1:0]  start,
  output logic [NUM_FU-1:0] pick
);

  logic             found;
  logic [PTR_W-1:0] idx;
  int unsigned      sum;

  always_comb begin
    pick  = '0;
    found = 1'b0;
    idx   = '0;
    sum   = 0;
    for (int unsigned i = 0; i < NUM_FU; i++) begin
      sum = 32'(start) + i;
      if (sum >= NUM_FU) sum = sum - NUM_FU;
      idx = PTR_W'(sum);
      if (!found && req[idx]) begin
        pick[idx] = 1'b1;
        found     = 1'b1;
      end
    end
  end

endmodule

// File: rtl/cdb_arbiter.sv
// Common data bus arbiter: grants up to CDB_SZ completed functional units per
// cycle in round-robin order and broadcasts their results one cycle later.
module cdb_arbiter
  import sys_defs::*;
#(
  parameter int unsigned NUM_FU = 4,
  parameter int unsigned CDB_SZ = 2,
  parameter int unsigned DATA_W = 32
) (
  input  logic                                   clock,
  input  logic                                   reset,
  input  logic                                   flush,
  input  logic [NUM_FU-1:0]                      req_valid,
  input  logic [NUM_FU-1:0][PHYS_REG_BITS-1:0]   req_tag,
  input  logic [NUM_FU-1:0][DATA_W-1:0]          req_value,
  output logic [NUM_FU-1:0]                      grant,
  output logic [CDB_SZ-1:0]                      cdb_valid,
  output logic [CDB_SZ-1:0][PHYS_REG_BITS-1:0]   cdb_tag,
  output logic [CDB_SZ-1:0][DATA_W-1:0]          cdb_value
);

  localparam int unsigned PTR_W = (NUM_FU > 1) ? $clog2(NUM_FU) : 1;

  if (DATA_W > XLEN) begin : g_width_check
    $error("cdb_arbiter: DATA_W exceeds packet value width");
  end

  logic [PTR_W-1:0]                rr_ptr, rr_ptr_next;
  logic [CDB_SZ:0][NUM_FU-1:0]     avail;
  logic [CDB_SZ-1:0][NUM_FU-1:0]   pick;
  cdb_packet_t [CDB_SZ-1:0]        lane_d, lane_q;
  logic [PTR_W-1:0]                last_idx;
  logic                            any_grant;

  assign avail[0] = (!reset && !flush) ? req_valid : '0;

  // Every lane scans from rr_ptr; masking earlier picks keeps lane k the k-th in scan order
  for (genvar k = 0; k < CDB_SZ; k++) begin : g_lane
    rr_select #(
      .NUM_FU(NUM_FU),
      .PTR_W (PTR_W)
    ) u_select (
      .req  (avail[k]),
      .start(rr_ptr),
      .pick (pick[k])
    );
    assign avail[k+1] = avail[k] & ~pick[k];
  end

  assign grant = avail[0] & ~avail[CDB_SZ];

  always_comb begin
    lane_d    = '0;
    last_idx  = rr_ptr;
    any_grant = 1'b0;
    for (int unsigned k = 0; k < CDB_SZ; k++) begin
      for (int unsigned i = 0; i < NUM_FU; i++) begin
        if (pick[k][i]) begin
          lane_d[k].valid = 1'b1;
          lane_d[k].tag   = req_tag[i];
          lane_d[k].value = XLEN'(req_value[i]);
          last_idx        = PTR_W'(i);
          any_grant       = 1'b1;
        end
      end
    end
  end

  always_comb begin
    rr_ptr_next = rr_ptr;
    if (any_grant) begin
      if (last_idx == PTR_W'(NUM_FU - 1)) rr_ptr_next = '0;
      else                                rr_ptr_next = last_idx + PTR_W'(1);
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      lane_q <= '0;
      rr_ptr <= '0;
    end else begin
      lane_q <= lane_d;
      rr_ptr <= rr_ptr_next;
    end
  end

  always_comb begin
    cdb_valid = '0;
    cdb_tag   = '0;
    cdb_value = '0;
    for (int unsigned k = 0; k < CDB_SZ; k++) begin
      cdb_valid[k] = lane_q[k].valid;
      cdb_tag[k]   = lane_q[k].tag;
      cdb_value[k] = lane_q[k].value[DATA_W-1:0];
    end
  end

endmodule

// File: tb/tb_cdb_arbiter.sv
// Self-checking bench for cdb_arbiter: directed scenarios followed by random
// request traffic compared against a scan-list reference model.
module tb_cdb_arbiter;
  import sys_defs::*;

  localparam int NUM_FU = 4;
  localparam int CDB_SZ = 2;
  localparam int DATA_W = 32;
  localparam int BOUND  = (NUM_FU + CDB_SZ - 1) / CDB_SZ;

  logic                                 clock = 1'b0;
  logic                                 reset;
  logic                                 flush;
  logic [NUM_FU-1:0]                    req_valid;
  logic [NUM_FU-1:0][PHYS_REG_BITS-1:0] req_tag;
  logic [NUM_FU-1:0][DATA_W-1:0]        req_value;
  logic [NUM_FU-1:0]                    grant;
  logic [CDB_SZ-1:0]                    cdb_valid;
  logic [CDB_SZ-1:0][PHYS_REG_BITS-1:0] cdb_tag;
  logic [CDB_SZ-1:0][DATA_W-1:0]        cdb_value;

  cdb_arbiter #(
    .NUM_FU(NUM_FU),
    .CDB_SZ(CDB_SZ),
    .DATA_W(DATA_W)
  ) dut (
    .clock    (clock),
    .reset    (reset),
    .flush    (flush),
    .req_valid(req_valid),
    .req_tag  (req_tag),
    .req_value(req_value),
    .grant    (grant),
    .cdb_valid(cdb_valid),
    .cdb_tag  (cdb_tag),
    .cdb_value(cdb_value)
  );

  always #5 clock = ~clock;

  int total = 0;
  int bad   = 0;

  // reference model state
  int                         m_ptr = 0;
  logic [CDB_SZ-1:0]          m_valid = '0;
  logic [PHYS_REG_BITS-1:0]   m_tag [CDB_SZ];
  logic [DATA_W-1:0]          m_val [CDB_SZ];
  int                         waited [NUM_FU];
  logic [NUM_FU-1:0]          seen_grant;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s at %0t: got=%0h expected=%0h", tag, $time, got, exp);
    end
  endtask

  // Called at posedge+1 with inputs already driven; returns at the next posedge+1.
  task automatic run_cycle(output logic [NUM_FU-1:0] eg);
    int                       cnt;
    int                       last;
    int                       np;
    int                       i;
    logic [CDB_SZ-1:0]        nv;
    logic [PHYS_REG_BITS-1:0] nt [CDB_SZ];
    logic [DATA_W-1:0]        nd [CDB_SZ];
    eg   = '0;
    cnt  = 0;
    last = 0;
    np   = m_ptr;
    nv   = '0;
    for (int k = 0; k < CDB_SZ; k++) begin
      nt[k] = '0;
      nd[k] = '0;
    end
    if (reset) begin
      np = 0;
    end else if (!flush) begin
      for (int off = 0; off < NUM_FU; off++) begin
        i = (m_ptr + off) % NUM_FU;
        if (req_valid[i] && cnt < CDB_SZ) begin
          eg[i]   = 1'b1;
          nv[cnt] = 1'b1;
          nt[cnt] = req_tag[i];
          nd[cnt] = req_value[i];
          cnt++;
          last = i;
        end
      end
      if (cnt > 0) np = (last + 1) % NUM_FU;
    end

    #2;
    seen_grant = grant;
    check("grant", 64'(grant), 64'(eg));

    if (reset) begin
      for (int f = 0; f < NUM_FU; f++) waited[f] = 0;
    end else if (!flush) begin
      for (int f = 0; f < NUM_FU; f++) begin
        if (req_valid[f]) begin
          if (eg[f]) begin
            check("starve", 64'(waited[f] < BOUND), 64'd1);
            waited[f] = 0;
          end else begin
            waited[f]++;
          end
        end
      end
    end

    @(posedge clock);
    #1;
    m_ptr   = np;
    m_valid = nv;
    for (int k = 0; k < CDB_SZ; k++) begin
      m_tag[k] = nt[k];
      m_val[k] = nd[k];
      check("lane_valid", 64'(cdb_valid[k]), 64'(m_valid[k]));
      check("lane_tag",   64'(cdb_tag[k]),   64'(m_tag[k]));
      check("lane_value", 64'(cdb_value[k]), 64'(m_val[k]));
    end
    check("rr_ptr", 64'(dut.rr_ptr), 64'(m_ptr));
  endtask

  logic [NUM_FU-1:0] g;
  logic [NUM_FU-1:0] pend;
  int                bcast [NUM_FU];
  logic [NUM_FU-1:0] exp_seq [4];

  initial begin
    for (int f = 0; f < NUM_FU; f++) waited[f] = 0;
    for (int k = 0; k < CDB_SZ; k++) begin
      m_tag[k] = '0;
      m_val[k] = '0;
    end
    reset     = 1'b1;
    flush     = 1'b0;
    req_valid = '0;
    req_tag   = '0;
    req_value = '0;
    run_cycle(g);
    run_cycle(g);

    // idle after reset
    reset = 1'b0;
    run_cycle(g);
    check("idle_grant", 64'(seen_grant), 64'b0000);
    check("idle_valid", 64'(cdb_valid), 64'b00);
    check("idle_ptr", 64'(dut.rr_ptr), 64'd0);

    // two of three requesters granted in index order
    req_tag[0] = 6'd5;  req_value[0] = 32'hA000_0005;
    req_tag[1] = 6'd9;  req_value[1] = 32'hA000_0009;
    req_tag[3] = 6'd12; req_value[3] = 32'hA000_000C;
    req_valid  = 4'b1011;
    run_cycle(g);
    check("pair_grant", 64'(seen_grant), 64'b0011);
    check("pair_valid", 64'(cdb_valid), 64'b11);
    check("pair_tag0", 64'(cdb_tag[0]), 64'd5);
    check("pair_tag1", 64'(cdb_tag[1]), 64'd9);
    check("pair_ptr", 64'(dut.rr_ptr), 64'd2);

    // held FU3 alone, pointer wraps
    req_valid = 4'b1000;
    run_cycle(g);
    check("wrap_grant", 64'(seen_grant), 64'b1000);
    check("wrap_valid", 64'(cdb_valid), 64'b01);
    check("wrap_tag0", 64'(cdb_tag[0]), 64'd12);
    check("wrap_tag1", 64'(cdb_tag[1]), 64'd0);
    check("wrap_val1", 64'(cdb_value[1]), 64'd0);
    check("wrap_ptr", 64'(dut.rr_ptr), 64'd0);

    // all four continuously asserted
    for (int f = 0; f < NUM_FU; f++) begin
      req_tag[f]   = 6'(f + 1);
      req_value[f] = 32'(f * 16 + 7);
      bcast[f]     = 0;
    end
    exp_seq[0] = 4'b0011; exp_seq[1] = 4'b1100;
    exp_seq[2] = 4'b0011; exp_seq[3] = 4'b1100;
    req_valid = 4'b1111;
    for (int c = 0; c < 4; c++) begin
      run_cycle(g);
      check("full_grant", 64'(seen_grant), 64'(exp_seq[c]));
      for (int k = 0; k < CDB_SZ; k++)
        if (cdb_valid[k] && cdb_tag[k] >= 1 && cdb_tag[k] <= NUM_FU)
          bcast[int'(cdb_tag[k]) - 1]++;
    end
    for (int f = 0; f < NUM_FU; f++) check("full_bcast", 64'(bcast[f]), 64'd2);

    // flush leaves the pointer where it was
    run_cycle(g);
    check("pre_flush_ptr", 64'(dut.rr_ptr), 64'd2);
    flush = 1'b1;
    run_cycle(g);
    check("flush_grant", 64'(seen_grant), 64'b0000);
    check("flush_valid", 64'(cdb_valid), 64'b00);
    check("flush_ptr", 64'(dut.rr_ptr), 64'd2);

    // reset while lanes valid
    flush     = 1'b0;
    req_valid = 4'b1011;
    run_cycle(g);
    check("pre_rst_valid", 64'(cdb_valid), 64'b11);
    check("pre_rst_ptr", 64'(dut.rr_ptr), 64'd1);
    reset = 1'b1;
    run_cycle(g);
    check("rst_grant", 64'(seen_grant), 64'b0000);
    check("rst_valid", 64'(cdb_valid), 64'b00);
    check("rst_ptr", 64'(dut.rr_ptr), 64'd0);
    reset = 1'b0;

    // random traffic: each FU holds its request until granted
    pend      = '0;
    req_valid = '0;
    for (int f = 0; f < NUM_FU; f++) waited[f] = 0;
    for (int c = 0; c < 400; c++) begin
      for (int f = 0; f < NUM_FU; f++) begin
        if (!pend[f] && ($urandom_range(0, 1) == 1)) begin
          pend[f]      = 1'b1;
          req_tag[f]   = 6'($urandom);
          req_value[f] = $urandom;
        end
      end
      req_valid = pend;
      reset     = ($urandom_range(0, 59) == 0);
      flush     = !reset && ($urandom_range(0, 9) == 0);
      run_cycle(g);
      pend = pend & ~g;
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
